det_result_reader: RTL
======================

DET_RESULT_READER -- requirements
Module: det_result_reader

Interface
REQ-001 Parameter A_WIDTH, default 17, result-memory address width.
REQ-002 Parameter D_WIDTH, default 16, determinant word width.
REQ-003 Parameter DET_SIZE, default 75516, number of result words scanned per run.
REQ-004 Clk  input  1  single clock, all state on rising edge.
REQ-005 Rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 Go  input  1  start pulse, sampled only in IDLE.
REQ-007 D_Addr  output  A_WIDTH  result-SRAM read address.
REQ-008 D_Data  input  D_WIDTH  result-SRAM read data, valid exactly one cycle after the enabled read.
REQ-009 O_RW  output  1  SRAM direction, held 0 (read) at all times.
REQ-010 O_En  output  1  SRAM access enable, one read per asserted cycle.
REQ-011 Out_Valid  output  1  stream word valid.
REQ-012 Out_Ready  input  1  stream consumer ready; transfer when Out_Valid and Out_Ready are both high.
REQ-013 Out_Data  output  D_WIDTH  nonzero determinant value.
REQ-014 Out_Index  output  A_WIDTH  address the value was read from.
REQ-015 Count  output  A_WIDTH  number of nonzero words found in the current/last run.
REQ-016 Done  output  1  one-cycle pulse at end of run.

Function
REQ-017 FSM states: IDLE, SCAN, DRAIN, FIN; IDLE->SCAN on Go; SCAN->DRAIN after address DET_SIZE-1 issued; DRAIN->FIN when no read in flight and FIFO empty; FIN->IDLE unconditionally after one cycle.
REQ-018 Entering SCAN: read address = 0, Count = 0, FIFO cleared.
REQ-019 In SCAN, O_En = 1 only when FIFO occupancy plus in-flight read < 2; address increments by 1 per issued read, with no wrap past DET_SIZE-1.
REQ-020 Returned word equal to 0 is discarded; a nonzero word is pushed with its address into a 2-entry FIFO and Count increments by 1.
REQ-021 Out_Valid = FIFO not empty; Out_Data/Out_Index = FIFO head; both stable while Out_Valid=1 and Out_Ready=0.
REQ-022 Simultaneous push and pop on a full FIFO is legal; occupancy is unchanged and order is preserved.
REQ-023 Throughput: with Out_Ready held 1, one read per cycle, and a full scan of zero words takes DET_SIZE+2 cycles from Go to Done.
REQ-024 Latency: a nonzero word at address k, with Out_Ready=1 and no stall, appears on Out_Valid 2 cycles after its read is issued.
REQ-025 Done is high for exactly the FIN cycle; Count holds its final value until the next Go.
REQ-026 Go while not IDLE is ignored.
REQ-027 Count never overflows (DET_SIZE < 2^A_WIDTH); no saturation logic is required.

Reset
REQ-028 Rst_n low forces, asynchronously and including mid-run: state IDLE, D_Addr=0, O_En=0, O_RW=0, Out_Valid=0, Out_Data=0, Out_Index=0, Count=0, Done=0, FIFO empty, in-flight flag cleared.
REQ-029 After release, no SRAM access occurs until a new Go is sampled.

Structure
REQ-030 A_WIDTH, D_WIDTH and DET_SIZE defaults, plus the FSM state encoding, reside in the shared surf definitions package, together with the other SURF width constants.
REQ-031 The 2-entry FIFO is a sub-module named det_fifo2 (data plus index, with push, pop, full and empty); the remaining logic is flat.

Verification
REQ-032 Memory all zero, Out_Ready=1, Go pulse -> no Out_Valid, Done after DET_SIZE+2 cycles, Count=0.
REQ-033 Memory words 0x0005 at 3, 0xFFFF at 100 and 0x1234 at DET_SIZE-1 -> stream (3,0x0005), (100,0xFFFF), (DET_SIZE-1,0x1234) in order; Count=3.
REQ-034 All words nonzero, Out_Ready toggling 1 cycle on / 3 cycles off -> no loss or duplication, indices contiguous 0..DET_SIZE-1, O_En never asserted when FIFO plus in-flight equals 2.
REQ-035 Go re-pulsed at cycle 50 of a run -> ignored; the run completes with the same result as REQ-033.
REQ-036 Rst_n pulsed low mid-SCAN at address 1000 -> all outputs zero immediately; a later Go rescans from address 0.
REQ-037 Scoreboard compares the stream against the software-result file: every nonzero entry at index I equals the expected value at index I.

Source files
------------

// File: rtl/surf_pkg.sv
// Shared SURF definitions: datapath widths, result-scan sizing and the
// determinant reader state encoding.
package surf_pkg;

  localparam int SURF_A_WIDTH     = 17;
  localparam int SURF_D_WIDTH     = 16;
  localparam int SURF_DET_SIZE    = 75516;
  localparam int SURF_PIX_WIDTH   = 8;
  localparam int SURF_COORD_WIDTH = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } det_state_t;

endpackage

// File: rtl/det_fifo2.sv
// Two-entry FIFO carrying a determinant word and the address it came from.
// Push and pop together on a full FIFO keeps occupancy and order intact.
module det_fifo2 #(
  parameter int D_WIDTH = 16,
  parameter int A_WIDTH = 17
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               push,
  input  logic               pop,
  input  logic [D_WIDTH-1:0] push_data,
  input  logic [A_WIDTH-1:0] push_index,
  output logic [D_WIDTH-1:0] head_data,
  output logic [A_WIDTH-1:0] head_index,
  output logic               full,
  output logic               empty
);

  typedef struct packed {
    logic [A_WIDTH-1:0] index;
    logic [D_WIDTH-1:0] data;
  } entry_t;

  entry_t     mem [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] cnt;
  logic       do_push;
  logic       do_pop;

  assign full       = (cnt == 2'd2);
  assign empty      = (cnt == 2'd0);
  assign do_pop     = pop && !empty;
  assign do_push    = push && (!full || do_pop);
  assign head_data  = mem[rd_ptr].data;
  assign head_index = mem[rd_ptr].index;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the storage is reset too, because the head drives the stream
      // data/index outputs, which must read zero while in reset.
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else if (clear) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments make every register here sample the
      // pre-edge pointers, so a full-FIFO push lands in the slot being popped.
      if (do_push) begin
        mem[wr_ptr] <= '{index: push_index, data: push_data};
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/det_result_reader.sv
// Scans the determinant result SRAM and streams every nonzero word with its
// address through a two-entry FIFO, counting the hits of each run.
module det_result_reader
  import surf_pkg::*;
#(
  parameter int A_WIDTH  = SURF_A_WIDTH,
  parameter int D_WIDTH  = SURF_D_WIDTH,
  parameter int DET_SIZE = SURF_DET_SIZE
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               Go,
  output logic [A_WIDTH-1:0] D_Addr,
  input  logic [D_WIDTH-1:0] D_Data,
  output logic               O_RW,
  output logic               O_En,
  output logic               Out_Valid,
  input  logic               Out_Ready,
  output logic [D_WIDTH-1:0] Out_Data,
  output logic [A_WIDTH-1:0] Out_Index,
  output logic [A_WIDTH-1:0] Count,
  output logic               Done
);

  localparam logic [A_WIDTH-1:0] LAST_ADDR = A_WIDTH'(DET_SIZE - 1);

  det_state_t         state;
  logic               in_flight;
  logic [A_WIDTH-1:0] rd_index;
  logic               fifo_clear;
  logic               fifo_push;
  logic               fifo_full;
  logic               fifo_empty;

  // A read is issued only if its word is guaranteed a FIFO slot on return:
  // occupancy plus the read already in flight must stay below two.
  assign O_RW       = 1'b0;
  assign O_En       = (state == SCAN) && !fifo_full && !(in_flight && !fifo_empty);
  assign fifo_push  = in_flight && (D_Data != '0);
  assign fifo_clear = (state == IDLE) && Go;
  assign Out_Valid  = !fifo_empty;

  det_fifo2 #(
    .D_WIDTH (D_WIDTH),
    .A_WIDTH (A_WIDTH)
  ) u_fifo (
    .clk        (Clk),
    .rst_n      (Rst_n),
    .clear      (fifo_clear),
    .push       (fifo_push),
    .pop        (Out_Ready),
    .push_data  (D_Data),
    .push_index (rd_index),
    .head_data  (Out_Data),
    .head_index (Out_Index),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      D_Addr    <= '0;
      in_flight <= 1'b0;
      rd_index  <= '0;
      Count     <= '0;
      Done      <= 1'b0;
    end else begin
      Done      <= 1'b0;
      in_flight <= O_En;
      if (O_En) rd_index <= D_Addr;
      if (fifo_push) Count <= Count + A_WIDTH'(1);
      case (state)
        IDLE: begin
          if (Go) begin
            state  <= SCAN;
            D_Addr <= '0;
            Count  <= '0;
          end
        end
        SCAN: begin
          // The address parks on the last word instead of wrapping.
          if (O_En) begin
            if (D_Addr == LAST_ADDR) state <= DRAIN;
            else                     D_Addr <= D_Addr + A_WIDTH'(1);
          end
        end
        DRAIN: begin
          if (!in_flight && fifo_empty) begin
            state <= FIN;
            Done  <= 1'b1;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
